alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares the single 32-bit ALU datapath between two requesters, e.g. the main execute path (port 0) and a branch/address helper (port 1).
- Arbitrates round-robin and accepts one operation at a time.
- Drives the ALU operand/control inputs for one execute cycle, then registers the ALU result and zero flag.
- Holds the tagged response under a valid/ready handshake until the consumer takes it.

Parameters:
- DW, 32, operand/result width; must match the ALU.
- CW, 4, ALU control code width.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req0_valid_i  input  1  requester 0 has an operation.
- req0_ready_o  output  1  requester 0's operation is accepted this cycle.
- req0_src1_i / req0_src2_i  input  DW  requester 0 operands.
- req0_ctrl_i  input  CW  requester 0 ALU control code.
- req1_valid_i, req1_ready_o, req1_src1_i, req1_src2_i, req1_ctrl_i: same for requester 1.
- alu_src1_o / alu_src2_o  output  DW  operands to the ALU.
- alu_ctrl_o  output  CW  control code to the ALU.
- alu_result_i  input  DW  ALU result.
- alu_zero_i  input  1  ALU zero flag.
- rsp_valid_o  output  1  response available.
- rsp_ready_i  input  1  consumer takes the response.
- rsp_id_o  output  1  requester that issued the response.
- rsp_result_o  output  DW  registered result.
- rsp_zero_o  output  1  registered zero flag.
- rsp_err_o  output  1  the control code was illegal.
- busy_o  output  1  state is not IDLE.

Behaviour:
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values:
  - All outputs 0.
  - Internal operand/ctrl registers 0.
  - last_grant = 1, so requester 0 wins the first tie.
- Reset asserted in any state aborts the transaction immediately; the pending operation is lost.
- IDLE:
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester != last_grant.
  - The granted reqN_ready_o is high combinationally in that cycle; the other ready is 0.
  - On the grant edge: latch src1, src2, ctrl and id; set last_grant = id.
  - Next state is EXEC for a legal ctrl, RESP for an illegal ctrl.
- Ready outputs are 0 in EXEC and RESP. A requester must hold its valid and operands stable until it sees ready.
- Legal ctrl codes: 0,1,2,3,4,6,7,8,9,10,11. Codes 5 and 12-15 are illegal.
- Illegal ctrl:
  - The ALU is not exercised.
  - RESP is entered with rsp_result_o = 0, rsp_zero_o = 1, rsp_err_o = 1.
- EXEC (exactly one cycle):
  - alu_src1_o, alu_src2_o and alu_ctrl_o are driven from the latched registers.
  - At the end of the cycle, alu_result_i → rsp_result_o and alu_zero_i → rsp_zero_o; rsp_err_o = 0.
  - Next state is RESP.
- ALU operand outputs hold their last latched values outside EXEC; they are not driven to 0.
- RESP:
  - rsp_valid_o = 1. rsp_id_o, rsp_result_o, rsp_zero_o and rsp_err_o are stable.
  - When rsp_ready_i = 1: rsp_valid_o falls on the next edge and the state returns to IDLE.
  - No new grant is made in the handshake cycle; the earliest next grant is the IDLE cycle after.
- Latency:
  - Legal op: grant edge → rsp_valid_o high 2 edges later.
  - Illegal op: 1 edge later.
  - Minimum issue interval for legal ops is 3 cycles.
- No combinational path from any reqN_valid_i to alu_*_o.
- rsp_ready_i high outside RESP is ignored.
- busy_o = 1 in EXEC and RESP.

Test Plan:
- Reset/idle: assert rst_i mid-cycle → all outputs 0 asynchronously. Release with both requester valids low → state stays IDLE, readies 0.
- Single add: req0 valid, src1 = 5, src2 = 7, ctrl = 2 → req0_ready_o = 1 for 1 cycle. Next cycle alu_ctrl_o = 2. Then rsp_valid_o = 1 with rsp_id_o = 0, rsp_result_o = 12, rsp_zero_o = 0. Holds until rsp_ready_i = 1.
- Round-robin: both valid continuously. req0 = sub 9-9 (ctrl 6), req1 = or 0xF0|0x0F (ctrl 1) → grant order 0,1,0,1. Responses are (id0, 0, zero = 1), (id1, 0xFF, zero = 0), repeating.
- Backpressure: hold rsp_ready_i = 0 for 10 cycles with req1 pending → rsp outputs stable and req1_ready_o = 0 throughout. Release rsp_ready_i → req1 is granted one cycle after the handshake.
- Illegal ctrl: req1 ctrl = 12 → rsp_valid_o = 1 one edge after the grant, with rsp_err_o = 1, result 0, zero 1. alu_ctrl_o is unchanged from its previous value.
- Reset mid-op: assert rst_i while in EXEC → no response is produced, last_grant = 1. After release, tied requests go to requester 0 first.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Request/ALU/response bundle between two requesters, the shared ALU and
// the response consumer. The slave side is the arbiter.
interface alu_share_arbiter_if #(
  parameter int DW = 32,
  parameter int CW = 4
);
  logic          req0_valid_i;
  logic          req0_ready_o;
  logic [DW-1:0] req0_src1_i;
  logic [DW-1:0] req0_src2_i;
  logic [CW-1:0] req0_ctrl_i;
  logic          req1_valid_i;
  logic          req1_ready_o;
  logic [DW-1:0] req1_src1_i;
  logic [DW-1:0] req1_src2_i;
  logic [CW-1:0] req1_ctrl_i;
  logic [DW-1:0] alu_src1_o;
  logic [DW-1:0] alu_src2_o;
  logic [CW-1:0] alu_ctrl_o;
  logic [DW-1:0] alu_result_i;
  logic          alu_zero_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic          rsp_id_o;
  logic [DW-1:0] rsp_result_o;
  logic          rsp_zero_o;
  logic          rsp_err_o;
  logic          busy_o;

  modport slave (
    input  req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    input  req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    input  alu_result_i, alu_zero_i, rsp_ready_i,
    output req0_ready_o, req1_ready_o,
    output alu_src1_o, alu_src2_o, alu_ctrl_o,
    output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o, busy_o
  );

  modport master (
    output req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    output req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    output alu_result_i, alu_zero_i, rsp_ready_i,
    input  req0_ready_o, req1_ready_o,
    input  alu_src1_o, alu_src2_o, alu_ctrl_o,
    input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters. One operation in
// flight: IDLE grants, EXEC drives the ALU for a cycle, RESP holds the
// tagged result until the consumer takes it. Illegal control codes skip
// the ALU and answer straight away with an error response.
module alu_share_arbiter #(
  parameter int DW = 32,
  parameter int CW = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  logic          last_grant;
  logic          gnt_any;
  logic          gnt_id;
  logic          ctrl_legal;
  logic [DW-1:0] sel_src1;
  logic [DW-1:0] sel_src2;
  logic [CW-1:0] sel_ctrl;
  logic [DW-1:0] alu_src1;
  logic [DW-1:0] alu_src2;
  logic [CW-1:0] alu_ctrl;
  logic          rsp_valid;
  logic          rsp_id;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero;
  logic          rsp_err;

  // On a tie the requester that did not win last time goes first.
  assign gnt_any  = bus.req0_valid_i | bus.req1_valid_i;
  assign gnt_id   = (bus.req0_valid_i & bus.req1_valid_i) ? ~last_grant : bus.req1_valid_i;
  assign sel_src1 = gnt_id ? bus.req1_src1_i : bus.req0_src1_i;
  assign sel_src2 = gnt_id ? bus.req1_src2_i : bus.req0_src2_i;
  assign sel_ctrl = gnt_id ? bus.req1_ctrl_i : bus.req0_ctrl_i;
  assign ctrl_legal = (sel_ctrl != CW'(5)) && (sel_ctrl < CW'(12));

  // Readies are only ever high in IDLE; gated by reset so every output is
  // low while reset is held.
  assign bus.req0_ready_o = !rst_i && (state == IDLE) && gnt_any && !gnt_id;
  assign bus.req1_ready_o = !rst_i && (state == IDLE) && gnt_any &&  gnt_id;
  assign bus.busy_o       = (state != IDLE);

  assign bus.alu_src1_o   = alu_src1;
  assign bus.alu_src2_o   = alu_src2;
  assign bus.alu_ctrl_o   = alu_ctrl;
  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.rsp_id_o     = rsp_id;
  assign bus.rsp_result_o = rsp_result;
  assign bus.rsp_zero_o   = rsp_zero;
  assign bus.rsp_err_o    = rsp_err;

  // Grant / execute / respond sequencing with registered outputs. The ALU
  // operand registers only load for legal ops, so an illegal op leaves the
  // ALU inputs untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      alu_src1   <= '0;
      alu_src2   <= '0;
      alu_ctrl   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            last_grant <= gnt_id;
            rsp_id     <= gnt_id;
            if (ctrl_legal) begin
              alu_src1 <= sel_src1;
              alu_src2 <= sel_src2;
              alu_ctrl <= sel_ctrl;
              state    <= EXEC;
            end else begin
              rsp_result <= '0;
              rsp_zero   <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end
          end
        end
        EXEC: begin
          rsp_result <= bus.alu_result_i;
          rsp_zero   <= bus.alu_zero_i;
          rsp_err    <= 1'b0;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
